// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline hazard controller for the 5-stage rv32i core. It watches the ID
//   source registers, the EX destination/load flag, the EX redirect and the
//   IF/MEM memory handshakes. From these it drives the PC and pipeline-register
//   load enables, the IF/ID flush and the controlmux select. It sequences
//   load-use bubbles, whole-pipe memory freezes and redirect flushes.
//
// Parameters
//   LU_BUBBLES  bubbles per load-use hazard (1 or 2)
//   PERF_CNT_W  width of the optional performance counters
//
// Ports
//   clk, rst                     core clock, synchronous active-high reset
//   id_rs1_i, id_rs2_i           ID source register indices
//   id_uses_rs1_i, id_uses_rs2_i ID instruction actually reads rs1/rs2
//   ex_rd_i, ex_mem_read_i       EX destination index and load flag
//   ex_redirect_i                EX resolved a taken branch/jump
//   imem_busy_i                  instruction fetch still outstanding
//   dmem_req_i, dmem_resp_i      data memory request / response
//   pc_load_o .. memwb_load_o    PC and pipeline-register load enables
//   ifid_flush_o                 IF/ID captures a NOP instead of the fetch
//   controlmux_sel_o             zero = inject bubble, normal = pass
//
// Configuration
//   HAZARD_PERF_EN  when defined, adds the saturating counters
//                   stall_cycles_o, bubble_cycles_o and flush_cnt_o.

package controlmux;
    typedef enum logic {
        zero   = 1'b0,
        normal = 1'b1
    } controlmux_sel_t;
endpackage

module hazard_sequencer #(
    parameter int LU_BUBBLES = 1,
    parameter int PERF_CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  id_rs1_i,
    input  logic [4:0]                  id_rs2_i,
    input  logic                        id_uses_rs1_i,
    input  logic                        id_uses_rs2_i,
    input  logic [4:0]                  ex_rd_i,
    input  logic                        ex_mem_read_i,
    input  logic                        ex_redirect_i,
    input  logic                        imem_busy_i,
    input  logic                        dmem_req_i,
    input  logic                        dmem_resp_i,
    output logic                        pc_load_o,
    output logic                        ifid_load_o,
    output logic                        idex_load_o,
    output logic                        exmem_load_o,
    output logic                        memwb_load_o,
    output logic                        ifid_flush_o,
    output controlmux::controlmux_sel_t controlmux_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]       stall_cycles_o,
    output logic [PERF_CNT_W-1:0]       bubble_cycles_o,
    output logic [PERF_CNT_W-1:0]       flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        MEM_STALL = 2'd2
    } state_t;

    // Only one or two bubbles make sense: one when MEM->EX load forwarding
    // exists, two when the load result is only forwarded from WB.
    if (LU_BUBBLES < 1 || LU_BUBBLES > 2) begin : g_bad_lu_bubbles
        $error("hazard_sequencer: LU_BUBBLES must be 1 or 2");
    end

    state_t     r_state;
    state_t     r_ret_state;
    logic [1:0] r_bub_cnt;
    logic       r_redir_pend;

    state_t     w_next_state;
    state_t     w_next_ret;
    state_t     w_eff_state;
    logic [1:0] w_next_bub;
    logic       w_next_redir;
    logic       w_mem_stall;
    logic       w_lu_hit;

    // A missing fetch or an unanswered data access freezes the whole pipe.
    assign w_mem_stall = imem_busy_i | (dmem_req_i & ~dmem_resp_i);

    // x0 is hard-wired to zero, so a load targeting it never creates a
    // dependency.
    assign w_lu_hit = ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                       (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

    // The release cycle of a freeze behaves as if the pipe had never left the
    // state it was frozen in, so decisions are made against that state.
    assign w_eff_state = (r_state == MEM_STALL) ? r_ret_state : r_state;

    // State register. bub_cnt, ret_state and the pending-redirect flag are
    // all carried across freezes untouched unless the next-state logic says
    // otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_ret_state  <= RUN;
            r_bub_cnt    <= 2'd0;
            r_redir_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ret_state  <= w_next_ret;
            r_bub_cnt    <= w_next_bub;
            r_redir_pend <= w_next_redir;
        end
    end

    // Next-state and output decode. Priority is reset, then memory freeze,
    // then redirect (live or remembered from a freeze), then load-use
    // bubbles, then a normal cycle.
    always_comb begin
        pc_load_o        = 1'b1;
        ifid_load_o      = 1'b1;
        idex_load_o      = 1'b1;
        exmem_load_o     = 1'b1;
        memwb_load_o     = 1'b1;
        ifid_flush_o     = 1'b0;
        controlmux_sel_o = controlmux::normal;
        w_next_state     = RUN;
        w_next_ret       = r_ret_state;
        w_next_bub       = r_bub_cnt;
        w_next_redir     = r_redir_pend;

        if (rst) begin
            pc_load_o        = 1'b0;
            ifid_load_o      = 1'b0;
            idex_load_o      = 1'b0;
            exmem_load_o     = 1'b0;
            memwb_load_o     = 1'b0;
            controlmux_sel_o = controlmux::zero;
            w_next_ret       = RUN;
            w_next_bub       = 2'd0;
            w_next_redir     = 1'b0;
        end else if (w_mem_stall) begin
            pc_load_o    = 1'b0;
            ifid_load_o  = 1'b0;
            idex_load_o  = 1'b0;
            exmem_load_o = 1'b0;
            memwb_load_o = 1'b0;
            w_next_state = MEM_STALL;
            // Remember where to resume only on the first frozen cycle.
            if (r_state != MEM_STALL) begin
                w_next_ret = r_state;
            end
            // A redirect resolved while frozen must not be lost; it is
            // applied on the release cycle.
            if (ex_redirect_i) begin
                w_next_redir = 1'b1;
            end
        end else if (ex_redirect_i | r_redir_pend) begin
            // The ID instruction is wrong-path, so any load-use hit is moot.
            ifid_flush_o     = 1'b1;
            controlmux_sel_o = controlmux::zero;
            w_next_state     = RUN;
            w_next_bub       = 2'd0;
            w_next_redir     = 1'b0;
        end else if (w_eff_state == LU_STALL) begin
            pc_load_o        = 1'b0;
            ifid_load_o      = 1'b0;
            controlmux_sel_o = controlmux::zero;
            w_next_bub       = (r_bub_cnt == 2'd0) ? 2'd0 : r_bub_cnt - 2'd1;
            w_next_state     = (r_bub_cnt <= 2'd1) ? RUN : LU_STALL;
        end else if (w_lu_hit) begin
            pc_load_o        = 1'b0;
            ifid_load_o      = 1'b0;
            controlmux_sel_o = controlmux::zero;
            // With one bubble, the bubble now in EX clears the hit by itself.
            if (LU_BUBBLES == 2) begin
                w_next_bub   = 2'd1;
                w_next_state = LU_STALL;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [PERF_CNT_W-1:0] L_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

    logic [PERF_CNT_W-1:0] r_stall_cnt;
    logic [PERF_CNT_W-1:0] r_bubble_cnt;
    logic [PERF_CNT_W-1:0] r_flush_cnt;
    logic                  w_perf_stall;
    logic                  w_perf_bubble;
    logic                  w_perf_flush;

    // Classify the current cycle from the decoded outputs: a bubble cycle is
    // the only non-reset cycle that zeroes the controlmux without flushing.
    assign w_perf_stall  = ~rst & w_mem_stall;
    assign w_perf_flush  = ~rst & ifid_flush_o;
    assign w_perf_bubble = ~rst & ~w_mem_stall & ~ifid_flush_o &
                           (controlmux_sel_o == controlmux::zero);

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_perf_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + L_ONE;
            end
            if (w_perf_bubble && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + L_ONE;
            end
            if (w_perf_flush && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + L_ONE;
            end
        end
    end

    assign stall_cycles_o  = r_stall_cnt;
    assign bubble_cycles_o = r_bubble_cnt;
    assign flush_cnt_o     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
//   Drives two hazard_sequencer instances (LU_BUBBLES = 1 and 2) from the same
//   input stream. Each cycle's expected outputs for both instances are pushed
//   to a scoreboard queue as the stimulus is applied and popped on the
//   following falling edge for comparison.
//   Expected output vector layout: {pc, ifid, idex, exmem, memwb, flush, sel==normal}.

module tb_hazard_sequencer;

    localparam logic [6:0] NORM  = 7'b1111101;
    localparam logic [6:0] FROZ  = 7'b0000001;
    localparam logic [6:0] BUB   = 7'b0011100;
    localparam logic [6:0] REDIR = 7'b1111110;
    localparam logic [6:0] RSTV  = 7'b0000000;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       ibusy;
        logic       req;
        logic       resp;
        logic [6:0] e1;
        logic [6:0] e2;
    } row_t;

    typedef struct {
        logic [6:0] e1;
        logic [6:0] e2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] idRs1, idRs2, exRd;
    logic       idUsesRs1, idUsesRs2, exMemRead, exRedirect;
    logic       imemBusy, dmemReq, dmemResp;

    logic pc1, ifid1, idex1, exmem1, memwb1, flush1;
    logic pc2, ifid2, idex2, exmem2, memwb2, flush2;
    controlmux::controlmux_sel_t sel1, sel2;

    exp_t sbQ[$];
    int   testCount = 0;
    int   failCount = 0;
    int   expStall1 = 0, expBub1 = 0, expFlush1 = 0;
    int   expStall2 = 0, expBub2 = 0, expFlush2 = 0;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall1, bubble1, fcnt1, stall2, bubble2, fcnt2;
`endif

    always #5 clk = ~clk;

    hazard_sequencer #(.LU_BUBBLES(1), .PERF_CNT_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_i(idRs1), .id_rs2_i(idRs2),
        .id_uses_rs1_i(idUsesRs1), .id_uses_rs2_i(idUsesRs2),
        .ex_rd_i(exRd), .ex_mem_read_i(exMemRead), .ex_redirect_i(exRedirect),
        .imem_busy_i(imemBusy), .dmem_req_i(dmemReq), .dmem_resp_i(dmemResp),
        .pc_load_o(pc1), .ifid_load_o(ifid1), .idex_load_o(idex1),
        .exmem_load_o(exmem1), .memwb_load_o(memwb1),
        .ifid_flush_o(flush1), .controlmux_sel_o(sel1)
`ifdef HAZARD_PERF_EN
        , .stall_cycles_o(stall1), .bubble_cycles_o(bubble1), .flush_cnt_o(fcnt1)
`endif
    );

    hazard_sequencer #(.LU_BUBBLES(2), .PERF_CNT_W(32)) dut2 (
        .clk(clk), .rst(rst),
        .id_rs1_i(idRs1), .id_rs2_i(idRs2),
        .id_uses_rs1_i(idUsesRs1), .id_uses_rs2_i(idUsesRs2),
        .ex_rd_i(exRd), .ex_mem_read_i(exMemRead), .ex_redirect_i(exRedirect),
        .imem_busy_i(imemBusy), .dmem_req_i(dmemReq), .dmem_resp_i(dmemResp),
        .pc_load_o(pc2), .ifid_load_o(ifid2), .idex_load_o(idex2),
        .exmem_load_o(exmem2), .memwb_load_o(memwb2),
        .ifid_flush_o(flush2), .controlmux_sel_o(sel2)
`ifdef HAZARD_PERF_EN
        , .stall_cycles_o(stall2), .bubble_cycles_o(bubble2), .flush_cnt_o(fcnt2)
`endif
    );

    // Packed observation of each instance in the expected-vector layout.
    function automatic logic [6:0] obs1();
        return {pc1, ifid1, idex1, exmem1, memwb1, flush1, sel1 == controlmux::normal};
    endfunction

    function automatic logic [6:0] obs2();
        return {pc2, ifid2, idex2, exmem2, memwb2, flush2, sel2 == controlmux::normal};
    endfunction

    // Build one stimulus row with the expected outputs of both instances.
    function automatic row_t mk(input int r, input int s1, input int s2, input int u1,
                                input int u2, input int rd, input int mr, input int rdr,
                                input int ib, input int rq, input int rp,
                                input logic [6:0] e1, input logic [6:0] e2);
        row_t t;
        t.rst = 1'(r);   t.rs1 = 5'(s1); t.rs2 = 5'(s2);
        t.u1 = 1'(u1);   t.u2 = 1'(u2);  t.rd = 5'(rd);
        t.mr = 1'(mr);   t.redir = 1'(rdr);
        t.ibusy = 1'(ib); t.req = 1'(rq); t.resp = 1'(rp);
        t.e1 = e1;       t.e2 = e2;
        return t;
    endfunction

    // Drive one cycle just after the rising edge, queue its expectation and
    // advance the counter model implied by the expected outputs.
    task automatic applyStimulus(input row_t t);
        exp_t e;
        @(posedge clk);
        #1;
        rst = t.rst; idRs1 = t.rs1; idRs2 = t.rs2;
        idUsesRs1 = t.u1; idUsesRs2 = t.u2; exRd = t.rd;
        exMemRead = t.mr; exRedirect = t.redir;
        imemBusy = t.ibusy; dmemReq = t.req; dmemResp = t.resp;
        e.e1 = t.e1;
        e.e2 = t.e2;
        sbQ.push_back(e);
        if (t.e1 == RSTV) begin expStall1 = 0; expBub1 = 0; expFlush1 = 0; end
        else if (t.e1 == FROZ) expStall1++;
        else if (t.e1 == BUB) expBub1++;
        else if (t.e1 == REDIR) expFlush1++;
        if (t.e2 == RSTV) begin expStall2 = 0; expBub2 = 0; expFlush2 = 0; end
        else if (t.e2 == FROZ) expStall2++;
        else if (t.e2 == BUB) expBub2++;
        else if (t.e2 == REDIR) expFlush2++;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, RSTV, RSTV));
        rows.push_back(mk(1, 1, 5, 1, 1, 5, 1, 1, 1, 1, 0, RSTV, RSTV));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM, NORM));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            e = sbQ.pop_front();
            testCount += 2;
            if (obs1() !== e.e1) begin
                failCount++;
                $display("[TB] FAIL reset[%0d] lu1: got %b want %b", i, obs1(), e.e1);
            end
            if (obs2() !== e.e2) begin
                failCount++;
                $display("[TB] FAIL reset[%0d] lu2: got %b want %b", i, obs2(), e.e2);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        // load x5 in EX, ID reads x5 as rs2
        rows.push_back(mk(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, BUB,  BUB));
        rows.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, NORM, BUB));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM, NORM));
        // hit through rs1
        rows.push_back(mk(0, 7, 2, 1, 1, 7, 1, 0, 0, 0, 0, BUB,  BUB));
        rows.push_back(mk(0, 7, 2, 1, 1, 0, 0, 0, 0, 0, 0, NORM, BUB));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM, NORM));
        // index matches but the register is not read
        rows.push_back(mk(0, 1, 9, 1, 0, 9, 1, 0, 0, 0, 0, NORM, NORM));
        // load to x0, ID reads x0 on both sources
        rows.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, NORM, NORM));
        // matching rd but not a load
        rows.push_back(mk(0, 4, 4, 1, 1, 4, 0, 0, 0, 0, 0, NORM, NORM));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            e = sbQ.pop_front();
            testCount += 2;
            if (obs1() !== e.e1) begin
                failCount++;
                $display("[TB] FAIL load_use[%0d] lu1: got %b want %b", i, obs1(), e.e1);
            end
            if (obs2() !== e.e2) begin
                failCount++;
                $display("[TB] FAIL load_use[%0d] lu2: got %b want %b", i, obs2(), e.e2);
            end
        end
    endtask

    task automatic test_mem_stall();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 1, 0, FROZ, FROZ));
        end
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 1, 1, NORM, NORM));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 1, 0, 0, FROZ, FROZ));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM, NORM));
        // freeze outranks a live load-use hit; the hit is handled on release
        rows.push_back(mk(0, 1, 6, 1, 1, 6, 1, 0, 1, 0, 0, FROZ, FROZ));
        rows.push_back(mk(0, 1, 6, 1, 1, 6, 1, 0, 0, 0, 0, BUB,  BUB));
        rows.push_back(mk(0, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0, NORM, BUB));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM, NORM));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            e = sbQ.pop_front();
            testCount += 2;
            if (obs1() !== e.e1) begin
                failCount++;
                $display("[TB] FAIL mem_stall[%0d] lu1: got %b want %b", i, obs1(), e.e1);
            end
            if (obs2() !== e.e2) begin
                failCount++;
                $display("[TB] FAIL mem_stall[%0d] lu2: got %b want %b", i, obs2(), e.e2);
            end
        end
    endtask

    task automatic test_redirect();
        row_t rows[$];
        exp_t e;
        // redirect pulse while frozen is held until release
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 1, 0, FROZ,  FROZ));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 1, 0, 1, 0, FROZ,  FROZ));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 1, 0, FROZ,  FROZ));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 1, 1, REDIR, REDIR));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM,  NORM));
        // redirect beats a coincident load-use hit, no bubble follows
        rows.push_back(mk(0, 8, 2, 1, 1, 8, 1, 1, 0, 0, 0, REDIR, REDIR));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM,  NORM));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            e = sbQ.pop_front();
            testCount += 2;
            if (obs1() !== e.e1) begin
                failCount++;
                $display("[TB] FAIL redirect[%0d] lu1: got %b want %b", i, obs1(), e.e1);
            end
            if (obs2() !== e.e2) begin
                failCount++;
                $display("[TB] FAIL redirect[%0d] lu2: got %b want %b", i, obs2(), e.e2);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        // freeze during the second bubble resumes that bubble on release
        rows.push_back(mk(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, BUB,   BUB));
        rows.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 1, 0, FROZ,  FROZ));
        rows.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 1, 1, NORM,  BUB));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM,  NORM));
        // redirect cancels a pending second bubble
        rows.push_back(mk(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, BUB,   BUB));
        rows.push_back(mk(0, 1, 5, 1, 1, 0, 0, 1, 0, 0, 0, REDIR, REDIR));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM,  NORM));
        // reset in the middle of a load-use stall returns to RUN
        rows.push_back(mk(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, BUB,   BUB));
        rows.push_back(mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, RSTV,  RSTV));
        rows.push_back(mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, NORM,  NORM));
        // two consecutive independent hazards
        rows.push_back(mk(0, 3, 2, 1, 0, 3, 1, 0, 0, 0, 0, BUB,   BUB));
        rows.push_back(mk(0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, NORM,  BUB));
        rows.push_back(mk(0, 4, 9, 0, 1, 9, 1, 0, 0, 0, 0, BUB,   BUB));
        rows.push_back(mk(0, 4, 9, 0, 1, 0, 0, 0, 0, 0, 0, NORM,  BUB));
        rows.push_back(mk(0, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, NORM,  NORM));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            e = sbQ.pop_front();
            testCount += 2;
            if (obs1() !== e.e1) begin
                failCount++;
                $display("[TB] FAIL back_to_back[%0d] lu1: got %b want %b", i, obs1(), e.e1);
            end
            if (obs2() !== e.e2) begin
                failCount++;
                $display("[TB] FAIL back_to_back[%0d] lu2: got %b want %b", i, obs2(), e.e2);
            end
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        // counters reflect all cycles since the last reset once the edge passes
        @(posedge clk);
        #1;
        testCount += 6;
        if (stall1 !== 32'(expStall1)) begin
            failCount++; $display("[TB] FAIL perf stall lu1: got %0d want %0d", stall1, expStall1);
        end
        if (bubble1 !== 32'(expBub1)) begin
            failCount++; $display("[TB] FAIL perf bubble lu1: got %0d want %0d", bubble1, expBub1);
        end
        if (fcnt1 !== 32'(expFlush1)) begin
            failCount++; $display("[TB] FAIL perf flush lu1: got %0d want %0d", fcnt1, expFlush1);
        end
        if (stall2 !== 32'(expStall2)) begin
            failCount++; $display("[TB] FAIL perf stall lu2: got %0d want %0d", stall2, expStall2);
        end
        if (bubble2 !== 32'(expBub2)) begin
            failCount++; $display("[TB] FAIL perf bubble lu2: got %0d want %0d", bubble2, expBub2);
        end
        if (fcnt2 !== 32'(expFlush2)) begin
            failCount++; $display("[TB] FAIL perf flush lu2: got %0d want %0d", fcnt2, expFlush2);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; idRs1 = '0; idRs2 = '0; idUsesRs1 = 1'b0; idUsesRs2 = 1'b0;
        exRd = '0; exMemRead = 1'b0; exRedirect = 1'b0;
        imemBusy = 1'b0; dmemReq = 1'b0; dmemResp = 1'b0;
        test_reset();
        test_load_use();
        test_mem_stall();
        test_redirect();
        test_back_to_back();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
